// File: rtl/lemming_bridge_pkg.sv
// lemming_bridge_pkg: shared types, default sizing and width helper for the
// single-lane bridge arbiter.
package lemming_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CROSS = 2'd1,
      COOL  = 2'd2
   } state_t;

   localparam int unsigned DEF_N            = 4;
   localparam int unsigned DEF_CROSS_CYCLES = 4;
   localparam int unsigned DEF_COOL_CYCLES  = 1;

   // Bits needed to index/count n distinct values; never less than one bit.
   function automatic int unsigned lb_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lemming_rr_pick.sv
// lemming_rr_pick: combinational round-robin picker. Returns the first
// eligible lemming found scanning upward from ptr, wrapping at N-1.
module lemming_rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = 2
) (
   input  logic [N-1:0]  elig,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);

   logic [PW-1:0] pos;

   // Walk offsets from farthest to nearest so the nearest eligible bit wins.
   always_comb begin
      valid = |elig;
      idx   = '0;
      pos   = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         pos = PW'((int'(ptr) + i) % int'(N));
         if (elig[pos]) begin
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/lemming_bridge_arbiter.sv
// lemming_bridge_arbiter: round-robin owner of the single-lane bridge.
// Grants one eligible lemming (req & ground) at a time for CROSS_CYCLES,
// then idles for COOL_CYCLES before the next arbitration.
// Optional feature macro: LEMMING_BRIDGE_ABORT_EN -- when defined, the owner
// losing ground mid-crossing aborts the crossing and pulses aaah.
module lemming_bridge_arbiter
   import lemming_bridge_pkg::*;
#(
   parameter int unsigned N            = DEF_N,
   parameter int unsigned CROSS_CYCLES = DEF_CROSS_CYCLES,
   parameter int unsigned COOL_CYCLES  = DEF_COOL_CYCLES,
   localparam int unsigned HW          = lb_width(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  ground,
   output logic [N-1:0]  grant,
   output logic [HW-1:0] holder,
   output logic          busy,
   output logic [N-1:0]  crossed,
   output logic          aaah
);

   localparam int unsigned CNT_MAX   = (CROSS_CYCLES > COOL_CYCLES) ? CROSS_CYCLES : COOL_CYCLES;
   localparam int unsigned CW        = lb_width(CNT_MAX);
   localparam int unsigned CROSS_END = CROSS_CYCLES - 1;
   localparam int unsigned COOL_END  = (COOL_CYCLES == 0) ? 0 : COOL_CYCLES - 1;

   state_t        state_q, state_d;
   logic [HW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  grant_d;
   logic [HW-1:0] holder_d;
   logic          busy_d;
   logic [N-1:0]  crossed_d;
   logic          aaah_d;
   logic          fell;
   logic [HW-1:0] ptr_after;

   logic          pick_vld;
   logic [HW-1:0] pick_idx;

   lemming_rr_pick #(
      .N  (N),
      .PW (HW)
   ) u_pick (
      .elig  (req & ground),
      .ptr   (ptr_q),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // Owner falling off mid-crossing; tied low when the abort feature is absent.
   always_comb begin
`ifdef LEMMING_BRIDGE_ABORT_EN
      fell = ~ground[holder];
`else
      fell = 1'b0;
`endif
   end

   // Next-state and next-output decisions; every register's next value defaults to hold/idle.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      grant_d   = grant;
      holder_d  = holder;
      crossed_d = '0;
      aaah_d    = 1'b0;
      ptr_after = (holder == HW'(N - 1)) ? '0 : holder + 1'b1;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d  = CROSS;
               grant_d  = N'(1) << pick_idx;
               holder_d = pick_idx;
               cnt_d    = '0;
            end
         end
         CROSS: begin
            if (fell || (cnt_q == CW'(CROSS_END))) begin
               grant_d = '0;
               ptr_d   = ptr_after;
               cnt_d   = '0;
               state_d = (COOL_CYCLES == 0) ? IDLE : COOL;
               if (fell) begin
                  aaah_d = 1'b1;
               end else begin
                  crossed_d = grant;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         COOL: begin
            if (cnt_q == CW'(COOL_END)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, pointer, counter and all registered outputs; reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant   <= '0;
         holder  <= '0;
         busy    <= 1'b0;
         crossed <= '0;
         aaah    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant   <= grant_d;
         holder  <= holder_d;
         busy    <= busy_d;
         crossed <= crossed_d;
         aaah    <= aaah_d;
      end
   end

endmodule

// File: tb/tb_lemming_bridge_arbiter.sv
// tb_lemming_bridge_arbiter: directed bench for lemming_bridge_arbiter with
// N=4, CROSS_CYCLES=4, COOL_CYCLES=1. Honours LEMMING_BRIDGE_ABORT_EN.
module tb_lemming_bridge_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] ground;
   logic [3:0] grant;
   logic [1:0] holder;
   logic       busy;
   logic [3:0] crossed;
   logic       aaah;

   int checks   = 0;
   int failures = 0;

   lemming_bridge_arbiter #(
      .N            (4),
      .CROSS_CYCLES (4),
      .COOL_CYCLES  (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .ground  (ground),
      .grant   (grant),
      .holder  (holder),
      .busy    (busy),
      .crossed (crossed),
      .aaah    (aaah)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge (drive and sample point).
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      req    = 4'b1111;
      ground = 4'b1111;
      tick(2);
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
      checks++; if (holder !== 2'd0) begin failures++; $display("FAIL reset_holder got=%0d exp=0", holder); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (crossed !== 4'b0000) begin failures++; $display("FAIL reset_crossed got=%b exp=0000", crossed); end
      checks++; if (aaah !== 1'b0) begin failures++; $display("FAIL reset_aaah got=%b exp=0", aaah); end
      reset = 1'b0;
      tick();
      checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", grant); end
      checks++; if (holder !== 2'd0) begin failures++; $display("FAIL reset_first_holder got=%0d exp=0", holder); end
      req = 4'b0000;
      tick(6);
   endtask

   task automatic test_single();
      req    = 4'b0100;
      ground = 4'b1111;
      tick();
      req = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant c=%0d got=%b exp=0100", c, grant); end
         checks++; if (holder !== 2'd2) begin failures++; $display("FAIL single_holder c=%0d got=%0d exp=2", c, holder); end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy c=%0d got=%b exp=1", c, busy); end
         checks++; if (crossed !== 4'b0000) begin failures++; $display("FAIL single_crossed_early c=%0d got=%b exp=0000", c, crossed); end
         tick();
      end
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_grant_end got=%b exp=0000", grant); end
      checks++; if (crossed !== 4'b0100) begin failures++; $display("FAIL single_crossed got=%b exp=0100", crossed); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_cool got=%b exp=1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_idle got=%b exp=0", busy); end
      checks++; if (crossed !== 4'b0000) begin failures++; $display("FAIL single_crossed_pulse got=%b exp=0000", crossed); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_order [5];
      logic [3:0] prev;
      int         got;
      int         last_cyc;
      exp_order[0] = 4'b0001;
      exp_order[1] = 4'b0010;
      exp_order[2] = 4'b0100;
      exp_order[3] = 4'b1000;
      exp_order[4] = 4'b0001;
      req   = 4'b0000;
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      req    = 4'b1111;
      ground = 4'b1111;
      prev     = 4'b0000;
      got      = 0;
      last_cyc = 0;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         tick();
         if (grant !== 4'b0000 && prev === 4'b0000) begin
            checks++; if (grant !== exp_order[got]) begin failures++; $display("FAIL rr_order n=%0d got=%b exp=%b", got, grant, exp_order[got]); end
            if (got > 0) begin
               checks++; if (cyc - last_cyc != 6) begin failures++; $display("FAIL rr_gap n=%0d got=%0d exp=6", got, cyc - last_cyc); end
            end
            last_cyc = cyc;
            got++;
         end
         prev = grant;
      end
      checks++; if (got != 5) begin failures++; $display("FAIL rr_count got=%0d exp=5", got); end
      req = 4'b0000;
      tick(6);
   endtask

   task automatic test_ineligible();
      req    = 4'b0010;
      ground = 4'b1101;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL inelig_grant c=%0d got=%b exp=0000", c, grant); end
      end
      ground = 4'b1111;
      tick();
      checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL inelig_release got=%b exp=0010", grant); end
      checks++; if (holder !== 2'd1) begin failures++; $display("FAIL inelig_holder got=%0d exp=1", holder); end
      req = 4'b0000;
      tick(6);
   endtask

   task automatic test_fall();
      req    = 4'b0010;
      ground = 4'b1111;
      tick();
      checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL fall_grant got=%b exp=0010", grant); end
      ground = 4'b1101;
`ifdef LEMMING_BRIDGE_ABORT_EN
      req = 4'b0101;
      tick();
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL abort_grant got=%b exp=0000", grant); end
      checks++; if (aaah !== 1'b1) begin failures++; $display("FAIL abort_aaah got=%b exp=1", aaah); end
      checks++; if (crossed !== 4'b0000) begin failures++; $display("FAIL abort_crossed got=%b exp=0000", crossed); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", busy); end
      tick();
      checks++; if (aaah !== 1'b0) begin failures++; $display("FAIL abort_aaah_pulse got=%b exp=0", aaah); end
      checks++; if (crossed !== 4'b0000) begin failures++; $display("FAIL abort_crossed_late got=%b exp=0000", crossed); end
      ground = 4'b1111;
      tick();
      checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL abort_next_grant got=%b exp=0100", grant); end
      req = 4'b0000;
      tick(6);
`else
      req = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL noabort_grant c=%0d got=%b exp=0010", c, grant); end
         checks++; if (aaah !== 1'b0) begin failures++; $display("FAIL noabort_aaah c=%0d got=%b exp=0", c, aaah); end
      end
      tick();
      checks++; if (crossed !== 4'b0010) begin failures++; $display("FAIL noabort_crossed got=%b exp=0010", crossed); end
      checks++; if (aaah !== 1'b0) begin failures++; $display("FAIL noabort_aaah_end got=%b exp=0", aaah); end
      ground = 4'b1111;
      tick(2);
`endif
   endtask

   task automatic test_reset_mid_cross();
      req    = 4'b0001;
      ground = 4'b1111;
      tick();
      req = 4'b0000;
      tick(2);
      checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL midrst_pre got=%b exp=0001", grant); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL midrst_grant got=%b exp=0000", grant); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (holder !== 2'd0) begin failures++; $display("FAIL midrst_holder got=%0d exp=0", holder); end
      checks++; if (crossed !== 4'b0000) begin failures++; $display("FAIL midrst_crossed got=%b exp=0000", crossed); end
      checks++; if (aaah !== 1'b0) begin failures++; $display("FAIL midrst_aaah got=%b exp=0", aaah); end
      tick();
      checks++; if (crossed !== 4'b0000) begin failures++; $display("FAIL midrst_crossed_late got=%b exp=0000", crossed); end
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL midrst_grant_late got=%b exp=0000", grant); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      req    = 4'b0000;
      ground = 4'b0000;
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_ineligible();
      test_fall();
      test_reset_mid_cross();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
